pipe_hazard_ctrl: RTL and testbench

- Parametrised hazard and forwarding controller for the 5-stage pipelined CPU.
- It replaces the fixed EX/MEM forwarding selects that are currently computed inside instruction decode.
- It keeps its own scoreboard that shadows the in-flight register writes in EX..WB.
- From that scoreboard it generates forwarding selects, load-use stalls, branch flushes and multi-cycle (mult/div) EX holds for the pipeline registers.
- It sits beside ControlUnit in ID and drives the enable/flush inputs of PC, IF_ID, ID_EX and EX_MEM.

---
 rtl/pipe_hazard_ctrl.sv | 120 ++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and forwarding controller for the 5-stage pipeline: shadows in-flight
// register writes in EX..WB and derives forwarding selects, stalls, flushes and EX holds.
module pipe_hazard_ctrl #(
  parameter  int ADDR_W = 5,
  parameter  int DEPTH  = 3,
  parameter  int MD_LAT = 4,
  localparam int FSEL_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic              id_wr_en,
  input  logic [ADDR_W-1:0] id_wr_addr,
  input  logic              id_is_load,
  input  logic              id_is_md,
  input  logic [1:0]        id_rs_en,
  input  logic [ADDR_W-1:0] id_rs_addr_a,
  input  logic [ADDR_W-1:0] id_rs_addr_b,
  input  logic              ex_branch_taken,
  output logic [FSEL_W-1:0] fwd_sel_a,
  output logic [FSEL_W-1:0] fwd_sel_b,
  output logic              pc_en,
  output logic              if_id_en,
  output logic              if_id_flush,
  output logic              id_ex_bubble,
  output logic              ex_hold,
  output logic              md_busy
);
  localparam int CNT_W = $clog2(MD_LAT + 1);

  typedef struct packed {
    logic              valid;
    logic              wr_en;
    logic [ADDR_W-1:0] addr;
    logic              is_load;
    logic              is_md;
  } rec_t;

  rec_t              s_q [1:DEPTH];
  rec_t              s_d [1:DEPTH];
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [FSEL_W-1:0] sel_a, sel_b;
  logic              hold, s1_unready, load_use;

  // Scan oldest to youngest so the youngest matching producer ends up selected.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (id_rs_en[0] && (id_rs_addr_a != '0) && s_q[k].valid && s_q[k].wr_en &&
          (s_q[k].addr == id_rs_addr_a))
        sel_a = FSEL_W'(k);
      if (id_rs_en[1] && (id_rs_addr_b != '0) && s_q[k].valid && s_q[k].wr_en &&
          (s_q[k].addr == id_rs_addr_b))
        sel_b = FSEL_W'(k);
    end
  end

  assign hold       = (cnt_q != '0);
  assign s1_unready = s_q[1].is_load | (s_q[1].is_md & hold);
  assign load_use   = id_valid & s1_unready &
                      ((sel_a == FSEL_W'(1)) | (sel_b == FSEL_W'(1)));

  always_comb begin
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    ex_hold      = 1'b0;
    md_busy      = 1'b0;
    fwd_sel_a    = '0;
    fwd_sel_b    = '0;
    if (!rst) begin
      ex_hold   = hold;
      md_busy   = hold;
      fwd_sel_a = sel_a;
      fwd_sel_b = sel_b;
      if (hold) begin
        pc_en    = 1'b0;
        if_id_en = 1'b0;
      end else if (ex_branch_taken) begin
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
      end else if (load_use) begin
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        id_ex_bubble = 1'b1;
      end
    end
  end

  // While EX is held the op stays in stage 1 and NOPs drain into MEM behind it.
  always_comb begin
    s_d   = s_q;
    cnt_d = cnt_q;
    if (hold) begin
      for (int k = DEPTH; k >= 3; k--) s_d[k] = s_q[k-1];
      s_d[2].valid = 1'b0;
      cnt_d        = cnt_q - 1'b1;
    end else begin
      for (int k = DEPTH; k >= 2; k--) s_d[k] = s_q[k-1];
      s_d[1].valid   = id_valid & ~id_ex_bubble;
      s_d[1].wr_en   = id_wr_en;
      s_d[1].addr    = id_wr_addr;
      s_d[1].is_load = id_is_load;
      s_d[1].is_md   = id_is_md;
      if ((MD_LAT > 1) && s_d[1].valid && id_is_md) cnt_d = CNT_W'(MD_LAT - 1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 1; k <= DEPTH; k++) s_q[k].valid <= 1'b0;
      cnt_q <= '0;
    end else begin
      s_q   <= s_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed vector table for the pipeline scenarios,
// then randomized traffic compared against an instruction-queue reference model.
module tb_pipe_hazard_ctrl;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 3;
  localparam int MD_LAT = 4;
  localparam int FSEL_W = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, id_valid, id_wr_en, id_is_load, id_is_md, ex_branch_taken;
  logic [ADDR_W-1:0] id_wr_addr, id_rs_addr_a, id_rs_addr_b;
  logic [1:0]        id_rs_en;
  logic [FSEL_W-1:0] fwd_sel_a, fwd_sel_b;
  logic              pc_en, if_id_en, if_id_flush, id_ex_bubble, ex_hold, md_busy;

  pipe_hazard_ctrl #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .MD_LAT(MD_LAT)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_wr_en(id_wr_en),
    .id_wr_addr(id_wr_addr), .id_is_load(id_is_load), .id_is_md(id_is_md),
    .id_rs_en(id_rs_en), .id_rs_addr_a(id_rs_addr_a), .id_rs_addr_b(id_rs_addr_b),
    .ex_branch_taken(ex_branch_taken), .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b),
    .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
    .id_ex_bubble(id_ex_bubble), .ex_hold(ex_hold), .md_busy(md_busy)
  );

  typedef struct {
    bit rst, vld, we; int wa; bit ld, md; int rs, ra, rb; bit br;
    int sa, sb; bit pc, ie, fl, bub, hd;
  } vec_t;

  typedef struct {
    bit v, we; int a; bit ld, md;
  } mrec_t;

  vec_t       vecs[$];
  logic [8:0] exp_q[$];
  int         errors = 0;
  int         checks = 0;
  mrec_t      pipe[$];
  int         md_left;

  function automatic vec_t mk(bit r, bit v, bit we, int wa, bit ld, bit md, int rs, int ra,
                              int rb, bit br, int sa, int sb, bit pc, bit ie, bit fl,
                              bit bub, bit hd);
    vec_t t;
    t.rst = r; t.vld = v; t.we = we; t.wa = wa; t.ld = ld; t.md = md;
    t.rs = rs; t.ra = ra; t.rb = rb; t.br = br;
    t.sa = sa; t.sb = sb; t.pc = pc; t.ie = ie; t.fl = fl; t.bub = bub; t.hd = hd;
    return t;
  endfunction

  task automatic drive(input vec_t t);
    rst = t.rst; id_valid = t.vld; id_wr_en = t.we; id_wr_addr = ADDR_W'(t.wa);
    id_is_load = t.ld; id_is_md = t.md; id_rs_en = 2'(t.rs);
    id_rs_addr_a = ADDR_W'(t.ra); id_rs_addr_b = ADDR_W'(t.rb); ex_branch_taken = t.br;
  endtask

  task automatic cmp(input string name, input int idx, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input int idx);
    logic [8:0] e;
    if (exp_q.size() == 0) begin
      cmp({tag, "_exp_queue_empty"}, idx, 1, 0);
      return;
    end
    e = exp_q.pop_front();
    cmp({tag, "_fwd_sel_a"},    idx, int'(fwd_sel_a),    int'(e[8:7]));
    cmp({tag, "_fwd_sel_b"},    idx, int'(fwd_sel_b),    int'(e[6:5]));
    cmp({tag, "_pc_en"},        idx, int'(pc_en),        int'(e[4]));
    cmp({tag, "_if_id_en"},     idx, int'(if_id_en),     int'(e[3]));
    cmp({tag, "_if_id_flush"},  idx, int'(if_id_flush),  int'(e[2]));
    cmp({tag, "_id_ex_bubble"}, idx, int'(id_ex_bubble), int'(e[1]));
    cmp({tag, "_ex_hold"},      idx, int'(ex_hold),      int'(e[0]));
    cmp({tag, "_md_busy"},      idx, int'(md_busy),      int'(e[0]));
  endtask

  // Reference: pipe[0] is the instruction in EX, pipe[1] MEM, pipe[2] WB.
  function automatic int youngest(bit en, int a);
    if (!en || a == 0) return 0;
    for (int i = 0; i < pipe.size(); i++)
      if (pipe[i].v && pipe[i].we && pipe[i].a == a) return i + 1;
    return 0;
  endfunction

  task automatic model_step(input vec_t t, output logic [8:0] e);
    int sa, sb; bit pc, ie, fl, bub, hd, ex_not_ready, lu;
    mrec_t nop, ent;
    nop = '{v: 0, we: 0, a: 0, ld: 0, md: 0};
    sa = youngest(t.rs[0], t.ra);
    sb = youngest(t.rs[1], t.rb);
    ex_not_ready = pipe[0].ld || (pipe[0].md && md_left > 0);
    lu = t.vld && ex_not_ready && (sa == 1 || sb == 1);
    pc = 1; ie = 1; fl = 0; bub = 0; hd = 0;
    if (t.rst) begin
      sa = 0; sb = 0;
      pipe = '{nop, nop, nop};
      md_left = 0;
    end else if (md_left > 0) begin
      pc = 0; ie = 0; hd = 1;
      pipe = '{pipe[0], nop, pipe[1]};
      md_left--;
    end else begin
      if (t.br) begin fl = 1; bub = 1; end
      else if (lu) begin pc = 0; ie = 0; bub = 1; end
      ent = '{v: t.vld && !bub, we: t.we, a: t.wa, ld: t.ld, md: t.md};
      pipe.push_front(ent);
      void'(pipe.pop_back());
      if (ent.v && ent.md) md_left = MD_LAT - 1;
    end
    e = {2'(sa), 2'(sb), pc, ie, fl, bub, hd};
  endtask

  initial begin
    vec_t t;
    logic [8:0] e;
    //         rst v we wa ld md rs ra  rb br | sa sb pc ie fl bub hd
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 3, 0, 0, 0, 0, 0, 0,  0, 0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 4, 0, 0, 3, 3, 3, 0,  1, 1, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 5, 1, 0, 0, 0, 0, 0,  0, 0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 6, 0, 0, 3, 5, 0, 0,  1, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 1, 1, 6, 0, 0, 3, 5, 0, 0,  2, 0, 1, 1, 0, 0, 0));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(0, 1, 1, 7, 0, 0, 0, 0, 0, 0,  0, 0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 1, 7, 0, 0,  1, 0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 1, 7, 0, 0,  2, 0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 1, 7, 0, 0,  3, 0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 1, 7, 0, 0,  0, 0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 8, 0, 1, 0, 0, 0, 0,  0, 0, 1, 1, 0, 0, 0));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(0, 1, 1, 9, 0, 0, 1, 8, 0, 0,  1, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 1, 9, 0, 0, 1, 8, 0, 0,  1, 0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 10, 1, 0, 0, 0, 0, 0,  0, 0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 11, 0, 0, 1, 10, 0, 1,  1, 0, 1, 1, 1, 1, 0));
    vecs.push_back(mk(0, 1, 1, 11, 0, 0, 1, 10, 0, 0,  2, 0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 12, 0, 1, 0, 0, 0, 0,  0, 0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 1, 12, 0, 0,  0, 0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 1, 0, 0, 0, 0, 0,  0, 0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 1, 0, 0, 3, 0, 0, 0,  0, 0, 1, 1, 0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      t = vecs[i];
      drive(t);
      exp_q.push_back({2'(t.sa), 2'(t.sb), t.pc, t.ie, t.fl, t.bub, t.hd});
      @(negedge clk);
      check_outs("tbl", i);
      @(posedge clk);
      #1;
    end

    md_left = 0;
    for (int i = 0; i < 400; i++) begin
      t = mk(i == 0 || $urandom_range(0, 39) == 0, $urandom_range(0, 7) != 0,
             $urandom_range(0, 3) != 0, $urandom_range(0, 3),
             $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 9) == 0, 0, 0, 0, 0, 0, 0, 0);
      drive(t);
      model_step(t, e);
      exp_q.push_back(e);
      @(negedge clk);
      check_outs("rnd", i);
      @(posedge clk);
      #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
